// File: rtl/tensor_core_fp8_seq.sv
// Sequencer that runs a 4x4xK FP8 GEMM on one combinational 4x4x4 tensor core,
// feeding the fp16 accumulator back as C each pass and returning the final tile.
module tensor_core_fp8_seq #(
  parameter int KT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [KT_W-1:0] k_tiles,
  input  logic [255:0]    c_init,
  output logic            busy,
  input  logic            ab_valid,
  output logic            ab_ready,
  input  logic [127:0]    a_tile,
  input  logic [127:0]    b_tile,
  output logic [127:0]    core_a,
  output logic [127:0]    core_b,
  output logic [255:0]    core_c,
  input  logic [255:0]    core_d,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [255:0]    d_out,
  output logic [KT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

  localparam logic [KT_W-1:0] ONE = KT_W'(1);

  state_t          state, state_nxt;
  logic [255:0]    acc;
  logic [KT_W-1:0] kt_reg;
  logic            beat, last_beat;

  assign beat      = ab_valid && ab_ready;
  assign last_beat = (step_cnt == kt_reg - ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // abort overrides every transition, including a start seen in IDLE
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (k_tiles != '0) ? RUN : OUT;
        RUN:     if (beat && last_beat) state_nxt = OUT;
        OUT:     if (d_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    ab_ready = (state == RUN) && !abort;
    d_valid  = (state == OUT);
    d_out    = d_valid ? acc : '0;
  end

  assign core_a = a_tile;
  assign core_b = b_tile;
  assign core_c = acc;

  // Aborted jobs leave acc/step_cnt as they were; only reset or a new start clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      kt_reg   <= '0;
      step_cnt <= '0;
    end else begin
      if (state == IDLE && start && !abort) begin
        acc      <= c_init;
        kt_reg   <= k_tiles;
        step_cnt <= '0;
      end else if (beat) begin
        acc      <= core_d;
        step_cnt <= step_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_tensor_core_fp8_seq.sv
// Directed bench for tensor_core_fp8_seq with a unit-tile stand-in for the E5M2 core.
module tb_tensor_core_fp8_seq;
  localparam int KT_W = 5;

  logic            clk = 0;
  logic            rst, start, abort, ab_valid, d_ready;
  logic [KT_W-1:0] k_tiles;
  logic [255:0]    c_init;
  logic [127:0]    a_tile, b_tile;
  logic            busy, ab_ready, d_valid;
  logic [127:0]    core_a, core_b;
  logic [255:0]    core_c, core_d, d_out;
  logic [KT_W-1:0] step_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tensor_core_fp8_seq #(.KT_W(KT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_tiles(k_tiles),
    .c_init(c_init), .busy(busy), .ab_valid(ab_valid), .ab_ready(ab_ready),
    .a_tile(a_tile), .b_tile(b_tile), .core_a(core_a), .core_b(core_b),
    .core_c(core_c), .core_d(core_d), .d_valid(d_valid), .d_ready(d_ready),
    .d_out(d_out), .step_cnt(step_cnt)
  );

  // A=B=all 1.0 gives D = C + 4.0 per element; only the fp16 values used here are tabulated
  function automatic logic [15:0] plus4(input logic [15:0] c);
    case (c)
      16'h0000: plus4 = 16'h4400;
      16'h3C00: plus4 = 16'h4500;
      16'h4400: plus4 = 16'h4800;
      16'h4500: plus4 = 16'h4880;
      16'h4800: plus4 = 16'h4A00;
      default:  plus4 = 16'hFFFF;
    endcase
  endfunction

  logic [127:0] ones8;
  assign ones8 = {16{8'h3C}};

  always_comb begin
    core_d = '1;
    if (core_a == ones8 && core_b == ones8)
      for (int e = 0; e < 16; e++) core_d[16*e +: 16] = plus4(core_c[16*e +: 16]);
  end

  function automatic logic [255:0] rep(input logic [15:0] v);
    rep = {16{v}};
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; ab_valid = 0; d_ready = 0;
    k_tiles = '0; c_init = '0; a_tile = {16{8'h3C}}; b_tile = {16{8'h3C}};
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%0b want=%0b", nm, act, exp); end
  endtask

  task automatic launch(input logic [KT_W-1:0] k, input logic [15:0] c);
    start = 1; k_tiles = k; c_init = rep(c);
    step();
    start = 0; k_tiles = '0; c_init = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1;
    step(); step();
    rst = 0; #1;
    total++;
    if ({busy, ab_ready, d_valid} !== 3'b000 || d_out !== '0 || step_cnt !== '0 || core_c !== '0) begin
      bad++; $display("FAIL reset busy=%0b rdy=%0b dv=%0b cnt=%0d", busy, ab_ready, d_valid, step_cnt);
    end
  endtask

  task automatic test_k1();
    launch(5'd1, 16'h0000);
    chk1("k1_ready", ab_ready, 1'b1);
    ab_valid = 1;
    step();
    ab_valid = 0; #1;
    chk1("k1_dvalid", d_valid, 1'b1);
    total++;
    if (d_out !== rep(16'h4400)) begin bad++; $display("FAIL k1_dout got=%h want=%h", d_out, rep(16'h4400)); end
    d_ready = 1;
    step();
    d_ready = 0; #1;
    chk1("k1_idle", busy, 1'b0);
  endtask

  task automatic test_k2();
    launch(5'd2, 16'h3C00);
    ab_valid = 1;
    step(); step();
    ab_valid = 0; #1;
    chk1("k2_dvalid", d_valid, 1'b1);
    total++;
    if (d_out !== rep(16'h4880)) begin bad++; $display("FAIL k2_dout got=%h want=%h", d_out, rep(16'h4880)); end
    total++;
    if (step_cnt !== 5'd2) begin bad++; $display("FAIL k2_cnt got=%0d want=2", step_cnt); end
    d_ready = 1; step(); d_ready = 0;
  endtask

  task automatic test_gaps();
    logic [5:0] pat;
    logic [15:0] exp_v;
    int n;
    pat = 6'b101001; // cycle order LSB first: 1,0,0,1,0,1
    n = 0;
    launch(5'd3, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      ab_valid = pat[i];
      step();
      if (pat[i]) n++;
      ab_valid = 0; #1;
      exp_v = (n == 0) ? 16'h0000 : (n == 1) ? 16'h4400 : (n == 2) ? 16'h4800 : 16'h4A00;
      total++;
      if (core_c !== rep(exp_v) || step_cnt !== KT_W'(n)) begin
        bad++; $display("FAIL gaps_acc cyc=%0d got=%h cnt=%0d want=%h cnt=%0d", i, core_c[15:0], step_cnt, exp_v, n);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (d_valid !== 1'b1 || d_out !== rep(16'h4A00)) begin
        bad++; $display("FAIL gaps_stall cyc=%0d dv=%0b got=%h want=%h", i, d_valid, d_out[15:0], 16'h4A00);
      end
      step();
    end
    d_ready = 1; step(); d_ready = 0; #1;
    chk1("gaps_idle", busy, 1'b0);
  endtask

  task automatic test_k0();
    start = 1; k_tiles = '0; c_init = rep(16'h4000);
    ab_valid = 1;
    step();
    start = 0; c_init = '0; #1;
    chk1("k0_dvalid", d_valid, 1'b1);
    chk1("k0_noready", ab_ready, 1'b0);
    total++;
    if (d_out !== rep(16'h4000)) begin bad++; $display("FAIL k0_dout got=%h want=%h", d_out, rep(16'h4000)); end
    ab_valid = 0; d_ready = 1; step(); d_ready = 0;
  endtask

  task automatic test_abort();
    launch(5'd3, 16'h0000);
    ab_valid = 1; step();
    abort = 1; #1;
    chk1("abort_ready_low", ab_ready, 1'b0);
    step();
    abort = 0; ab_valid = 0; #1;
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_no_dvalid", d_valid, 1'b0);
    total++;
    if (step_cnt !== 5'd1 || core_c !== rep(16'h4400)) begin
      bad++; $display("FAIL abort_hold cnt=%0d acc=%h want cnt=1 acc=4400", step_cnt, core_c[15:0]);
    end
    // start and abort together in IDLE: abort wins
    start = 1; abort = 1; k_tiles = 5'd1; step();
    start = 0; abort = 0; #1;
    chk1("abort_beats_start", busy, 1'b0);
    launch(5'd1, 16'h3C00);
    ab_valid = 1; step(); ab_valid = 0; #1;
    total++;
    if (d_valid !== 1'b1 || d_out !== rep(16'h4500)) begin
      bad++; $display("FAIL abort_rerun dv=%0b got=%h want=4500", d_valid, d_out[15:0]);
    end
    d_ready = 1; step(); d_ready = 0;
  endtask

  task automatic test_busy_start();
    launch(5'd2, 16'h0000);
    ab_valid = 1; step(); ab_valid = 0;
    start = 1; k_tiles = '0; c_init = rep(16'h4000);
    step();
    start = 0; c_init = '0; #1;
    total++;
    if (busy !== 1'b1 || d_valid !== 1'b0 || step_cnt !== 5'd1 || core_c !== rep(16'h4400)) begin
      bad++; $display("FAIL busy_start dv=%0b cnt=%0d acc=%h want run cnt=1 acc=4400", d_valid, step_cnt, core_c[15:0]);
    end
  endtask

  task automatic test_rst_mid();
    rst = 1; step(); rst = 0; #1;
    total++;
    if ({busy, ab_ready, d_valid} !== 3'b000 || core_c !== '0 || step_cnt !== '0) begin
      bad++; $display("FAIL rst_run busy=%0b cnt=%0d acc=%h", busy, step_cnt, core_c[15:0]);
    end
    launch(5'd0, 16'h4000);
    chk1("rst_out_pre", d_valid, 1'b1);
    rst = 1; step(); rst = 0; #1;
    total++;
    if ({busy, ab_ready, d_valid} !== 3'b000 || d_out !== '0 || core_c !== '0) begin
      bad++; $display("FAIL rst_out busy=%0b dv=%0b dout=%h", busy, d_valid, d_out[15:0]);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_k1();
    test_k2();
    test_gaps();
    test_k0();
    test_abort();
    test_busy_start();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
